// File: rtl/serial_sub_ctrl_if.sv
// Host-side bundle for serial_sub_ctrl: request/operands in, status/result out.
// The host drives through the master modport; the controller is the slave.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell walked LSB-first over WIDTH bits.
// Optional zero/overflow flags are built when SERSUB_FLAGS_EN is defined; otherwise both read 0.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_sub_ctrl_if.slave bus,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request that is accepted only on a clock edge where the
  // controller is IDLE (busy=0); it is ignored otherwise and never queued. Operands
  // are captured on that edge. done pulses for one cycle when diff/bout are new.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             bout_q;
  logic [CW-1:0]    cnt;

  logic             cell_x;
  logic             cell_y;
  logic             cell_z;
  logic             cell_d;
  logic             cell_b;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // The shared full-subtractor cell plus the result shift path.
  always_comb begin
    cell_x   = a_sh[0];
    cell_y   = b_sh[0];
    cell_z   = borrow;
    cell_d   = cell_x ^ cell_y ^ cell_z;
    cell_b   = (~cell_x & cell_y) | (~cell_x & cell_z) | (cell_y & cell_z);
    res_next = {cell_d, res[WIDTH-1:1]};
    last_bit = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= cell_b;
          res    <= res_next;
          cnt    <= cnt + CW'(1);
          // diff/bout stay at the previous result until the final bit lands.
          if (last_bit) begin
            diff_q <= res_next;
            bout_q <= cell_b;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign dbg_state = state;

`ifdef SERSUB_FLAGS_EN
  logic a_msb;
  logic b_msb;
  logic zero_q;
  logic ovf_q;

  // Operand sign bits are captured at accept since the shifters consume them.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if (state == S_RUN && last_bit) begin
        zero_q <= (res_next == '0);
        ovf_q  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: per-cycle comparison against a transaction-level
// model (busy window, done pulse, arithmetic result), plus directed literal expectations.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard / model: an accepted op keeps busy for W+1 cycles, the last one
  // carries done, and the result becomes visible together with done.
  logic [W-1:0] exp_q[$];
  logic [2:0]   flg_q[$];
  int           left = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_zero = 1'b0;
  logic         m_ovf  = 1'b0;
  int           m_full;
  logic [W-1:0] m_d;
  logic         m_z;
  logic         m_o;

  always @(posedge clk) begin
    if (rst) begin
      left   = 0;
      m_diff = '0;
      m_bout = 1'b0;
      m_zero = 1'b0;
      m_ovf  = 1'b0;
      exp_q.delete();
      flg_q.delete();
    end else if (left == 0) begin
      if (bus.start === 1'b1) begin
        m_full = int'(bus.a) - int'(bus.b) - int'(bus.bin);
        m_d    = W'(m_full);
`ifdef SERSUB_FLAGS_EN
        m_z = (m_d == '0);
        m_o = (bus.a[W-1] != bus.b[W-1]) && (m_d[W-1] != bus.a[W-1]);
`else
        m_z = 1'b0;
        m_o = 1'b0;
`endif
        exp_q.push_back(m_d);
        flg_q.push_back({m_full < 0, m_z, m_o});
        left = W + 1;
      end
    end else begin
      left--;
      if (left == 1) begin
        m_diff = exp_q.pop_front();
        {m_bout, m_zero, m_ovf} = flg_q.pop_front();
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(left > 0));
    check("done", 32'(bus.done), 32'(left == 1));
    check("diff", 32'(bus.diff), 32'(m_diff));
    check("bout", 32'(bus.bout), 32'(m_bout));
    check("zero", 32'(bus.zero), 32'(m_zero));
    check("ovf",  32'(bus.ovf),  32'(m_ovf));
  end

  // driver: call at a negedge while idle; returns at the first idle negedge after done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    lat       = 0;
    bcnt      = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom_range(0, 1));
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  int lat;
  int bcnt;
  int ndone;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic op, latency and busy window
    run_op(8'h05, 8'h03, 1'b0, lat, bcnt);
    check("lat_05_03", 32'(lat), 32'd9);
    check("busy_len", 32'(bcnt), 32'd9);
    check("diff_05_03", 32'(bus.diff), 32'h02);
    check("bout_05_03", 32'(bus.bout), 32'd0);

    run_op(8'h03, 8'h05, 1'b0, lat, bcnt);
    check("diff_03_05", 32'(bus.diff), 32'hFE);
    check("bout_03_05", 32'(bus.bout), 32'd1);

    run_op(8'h00, 8'h00, 1'b1, lat, bcnt);
    check("diff_00_00_b", 32'(bus.diff), 32'hFF);
    check("bout_00_00_b", 32'(bus.bout), 32'd1);

    // starts during RUN and during DONE are ignored
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 3) begin
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      end
      if (bus.done) begin
        ndone++;
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
      end
    end
    check("ignored_ndone", 32'(ndone), 32'd1);
    check("ignored_diff", 32'(bus.diff), 32'h0F);
    run_op(8'h20, 8'h01, 1'b0, lat, bcnt);
    check("after_ignore", 32'(bus.diff), 32'h1F);

    // reset mid-RUN
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.bin = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    run_op(8'hAA, 8'h55, 1'b0, lat, bcnt);
    check("diff_aa_55", 32'(bus.diff), 32'h55);

    // flag cases
    run_op(8'h80, 8'h01, 1'b0, lat, bcnt);
    check("diff_80_01", 32'(bus.diff), 32'h7F);
`ifdef SERSUB_FLAGS_EN
    check("ovf_80_01", 32'(bus.ovf), 32'd1);
`else
    check("ovf_80_01", 32'(bus.ovf), 32'd0);
`endif
    check("zero_80_01", 32'(bus.zero), 32'd0);
    run_op(8'h55, 8'h55, 1'b0, lat, bcnt);
    check("diff_55_55", 32'(bus.diff), 32'h00);
`ifdef SERSUB_FLAGS_EN
    check("zero_55_55", 32'(bus.zero), 32'd1);
`else
    check("zero_55_55", 32'(bus.zero), 32'd0);
`endif
    check("ovf_55_55", 32'(bus.ovf), 32'd0);

    // randomized traffic with spurious starts and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.bin   = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
